// File: rtl/alu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_defs (package)
//  Description : Shared definitions for the execute-stage ALU and the
//                multi-cycle multiply/divide unit. Holds the 6-bit function
//                encodings, the muldiv FSM state encodings and a helper that
//                classifies a function code as belonging to the muldiv unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_defs;

    // Single-cycle ALU function codes
    localparam logic [5:0] c_fn_sll   = 6'b000000;
    localparam logic [5:0] c_fn_srl   = 6'b000010;
    localparam logic [5:0] c_fn_sra   = 6'b000011;
    localparam logic [5:0] c_fn_sllv  = 6'b000100;
    localparam logic [5:0] c_fn_srlv  = 6'b000110;
    localparam logic [5:0] c_fn_srav  = 6'b000111;
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_xor   = 6'b100110;
    localparam logic [5:0] c_fn_nor   = 6'b100111;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_sltu  = 6'b101011;

    // Multiply/divide unit function codes (010xxx and 011xxx)
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mthi  = 6'b010001;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;
    localparam logic [5:0] c_fn_mtlo  = 6'b010011;
    localparam logic [5:0] c_fn_mult  = 6'b011000;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_div   = 6'b011010;
    localparam logic [5:0] c_fn_divu  = 6'b011011;

    // Muldiv FSM states
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_calc  = 2'd1;
    localparam logic [1:0] c_st_fix   = 2'd2;

    // Quotient reported for a zero divisor; sliced down to the operand width
    localparam int                   c_max_width     = 64;
    localparam logic [c_max_width-1:0] c_div0_quotient = '1;

    // True for any code in the 010xxx / 011xxx space owned by the muldiv unit
    function automatic logic is_muldiv_class(input logic [5:0] func);
        return (func & 6'b110000) == 6'b010000;
    endfunction

endpackage : alu_defs
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : Combinational single iteration of the multiply/divide
//                datapath. The accumulator is 2*WIDTH+1 bits wide.
//                Multiply: shift-add, multiplier in the low half, partial
//                product in the upper half (top bit is the add carry).
//                Divide: restoring, remainder in the upper half, dividend
//                shifting out of / quotient shifting into the low half.
//  Ports       : i_acc      - current accumulator
//                i_operand  - multiplicand (multiply) or divisor (divide)
//                i_is_div   - 0 = multiply step, 1 = divide step
//                o_acc_next - accumulator after one iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] i_acc,
    input  logic [WIDTH-1:0] i_operand,
    input  logic             i_is_div,
    output logic [2*WIDTH:0] o_acc_next
);

    logic [WIDTH:0]   w_mul_sum;
    logic [2*WIDTH:0] w_shifted;
    logic [WIDTH+1:0] w_diff;

    // Top accumulator bit is always zero between multiply steps, so including
    // it in the sum is harmless and keeps the add a plain WIDTH+1 bit add.
    assign w_mul_sum = i_acc[2*WIDTH:WIDTH] + {1'b0, i_operand & {WIDTH{i_acc[0]}}};

    assign w_shifted = {i_acc[2*WIDTH-1:0], 1'b0};
    // One extra bit so the sign of the trial subtraction acts as the borrow
    assign w_diff    = {1'b0, w_shifted[2*WIDTH:WIDTH]} - {2'b00, i_operand};

    always_comb begin
        o_acc_next = {1'b0, w_mul_sum, i_acc[WIDTH-1:1]};
        if (i_is_div) begin
            if (!w_diff[WIDTH+1]) begin
                o_acc_next = {w_diff[WIDTH:0], w_shifted[WIDTH-1:1], 1'b1};
            end else begin
                o_acc_next = w_shifted;
            end
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Multi-cycle multiply/divide unit with HI/LO registers.
//                MULT/MULTU/DIV/DIVU iterate one bit per cycle (WIDTH CALC
//                cycles plus one FIX cycle for sign correction and the HI/LO
//                write). MFHI/MFLO/MTHI/MTLO act in IDLE only.
//  Ports       : Clk_in    - clock, rising edge
//                Rst_n_in  - asynchronous reset, active low
//                Func_in   - 6-bit function code
//                Valid_in  - Func_in/A_in/B_in qualify this cycle
//                A_in      - rs operand (dividend, multiplicand, MT* data)
//                B_in      - rt operand (divisor, multiplier)
//                O_out     - MFHI/MFLO read data, otherwise 0
//                Busy_out  - iterative operation in flight
//                Stall_out - pipeline must hold the current instruction
//                Done_out  - one-cycle pulse, HI/LO hold the new result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk_in,
    input  logic             Rst_n_in,
    input  logic [5:0]       Func_in,
    input  logic             Valid_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] O_out,
    output logic             Busy_out,
    output logic             Stall_out,
    output logic             Done_out
);

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [2*WIDTH:0]   w_acc_next;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;

    logic               w_busy;
    logic               w_start;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    assign w_busy  = (r_state != c_st_idle);
    assign w_start = Valid_in && !w_busy &&
                     ((Func_in == c_fn_mult) || (Func_in == c_fn_multu) ||
                      (Func_in == c_fn_div)  || (Func_in == c_fn_divu));

    // Bit 0 of the start codes selects unsigned, bit 1 selects divide
    assign w_signed = ~Func_in[0];
    assign w_a_neg  = w_signed & A_in[WIDTH-1];
    assign w_b_neg  = w_signed & B_in[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -A_in : A_in;
    assign w_b_mag  = w_b_neg ? -B_in : B_in;

    assign Busy_out  = w_busy;
    assign Stall_out = Valid_in && is_muldiv_class(Func_in) && w_busy;
    assign Done_out  = r_done;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .i_is_div   (r_is_div),
        .o_acc_next (w_acc_next)
    );

    // Sign fix-up applied in FIX. Most-negative / -1 needs no special case:
    // the magnitude quotient 2^(WIDTH-1) negates back to itself.
    assign w_prod    = r_acc[2*WIDTH-1:0];
    assign w_mul_res = r_neg_q ? -w_prod : w_prod;
    assign w_quot    = r_acc[WIDTH-1:0];
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_hi_res = w_mul_res[2*WIDTH-1:WIDTH];
        w_lo_res = w_mul_res[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_lo_res = c_div0_quotient[WIDTH-1:0];
                w_hi_res = r_a;
            end else begin
                w_lo_res = r_neg_q ? -w_quot : w_quot;
                w_hi_res = r_neg_r ? -w_rem : w_rem;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_start) w_state_next = c_st_calc;
            c_st_calc: if (r_cnt == '0) w_state_next = c_st_fix;
            c_st_fix:  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_a       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_fix);
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_cnt     <= c_cnt_init;
                        r_is_div  <= Func_in[1];
                        r_a       <= A_in;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_div0    <= Func_in[1] && (B_in == '0);
                        // Divide iterates the dividend through the low half;
                        // multiply iterates the multiplier there instead.
                        r_acc     <= {{(WIDTH+1){1'b0}}, (Func_in[1] ? w_a_mag : w_b_mag)};
                        r_operand <= Func_in[1] ? w_b_mag : w_a_mag;
                    end else if (Valid_in && (Func_in == c_fn_mthi)) begin
                        r_hi <= A_in;
                    end else if (Valid_in && (Func_in == c_fn_mtlo)) begin
                        r_lo <= A_in;
                    end
                end
                c_st_calc: begin
                    r_acc <= w_acc_next;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_fix: begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        O_out = '0;
        if (Valid_in && !w_busy) begin
            if (Func_in == c_fn_mfhi) begin
                O_out = r_hi;
            end else if (Func_in == c_fn_mflo) begin
                O_out = r_lo;
            end
        end
    end

endmodule : alu_muldiv
`default_nettype wire
